// File: rtl/lock_cmd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// Shared definitions for lock_cmd_arbiter.
//
// OmpSsManager     : command field layout and command codes shared with the
//                    lock block and the accelerators.
// lock_cmd_arbiter_pkg : widths local to the arbiter datapath.
// ---------------------------------------------------------------------------
package OmpSsManager;
    localparam int          ACC_BITS        = 4;
    localparam int          CMD_TYPE_H      = 7;
    localparam int          CMD_TYPE_L      = 0;
    localparam logic [7:0]  CMD_LOCK_CODE   = 8'h04;
    localparam logic [7:0]  CMD_UNLOCK_CODE = 8'h05;
endpackage

package lock_cmd_arbiter_pkg;
    import OmpSsManager::*;

    localparam int TDATA_W = 64;
    localparam int TID_W   = 4;
    localparam int CMD_W   = CMD_TYPE_H - CMD_TYPE_L + 1;

    typedef logic [CMD_W-1:0]   cmd_code_t;
    typedef logic [TDATA_W-1:0] cmd_word_t;
endpackage

// File: rtl/lock_cmd_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: purely combinational round-robin pick.
//
// Ports:
//   i_elig        eligible request mask, one bit per port
//   i_rr_ptr      port with highest priority this cycle
//   o_grant_valid some port is eligible
//   o_grant_idx   first eligible port at or after i_rr_ptr (circular)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BITS = 4
) (
    input  logic [NUM_PORTS-1:0] i_elig,
    input  logic [PORT_BITS-1:0] i_rr_ptr,
    output logic                 o_grant_valid,
    output logic [PORT_BITS-1:0] o_grant_idx
);

    // Scan offsets from farthest to nearest so the nearest eligible port
    // (smallest circular distance from the pointer) is the last write.
    always_comb begin
        int j;
        j             = 0;
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            j = int'(i_rr_ptr) + k;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (i_elig[j]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = PORT_BITS'(j);
            end
        end
    end

endmodule

// File: rtl/lock_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// lock_cmd_arbiter: merges per-accelerator lock/unlock command streams into
// one registered stream for the lock block, tagging TID with the source port.
//
// Optional feature macro: LOCK_ARB_UNLOCK_PRIO_EN -- when defined, ports
// carrying an unlock command pre-empt ports carrying anything else.
//
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   inStream_TDATA      64-bit command per port, port i at [64*i +: 64]
//   inStream_TVALID     per-port valid
//   inStream_TREADY     per-port ready, one-hot or zero
//   outStream_TDATA     registered winning command
//   outStream_TVALID    output valid (high in SEND)
//   outStream_TREADY    ready from lock block
//   outStream_TID       winning port index, zero-extended to 4 bits
// ---------------------------------------------------------------------------
module lock_cmd_arbiter
    import OmpSsManager::*;
    import lock_cmd_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BITS = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [TDATA_W*NUM_PORTS-1:0] inStream_TDATA,
    input  logic [NUM_PORTS-1:0]         inStream_TVALID,
    output logic [NUM_PORTS-1:0]         inStream_TREADY,
    output logic [TDATA_W-1:0]           outStream_TDATA,
    output logic                         outStream_TVALID,
    input  logic                         outStream_TREADY,
    output logic [TID_W-1:0]             outStream_TID
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]           r_state;
    logic [PORT_BITS-1:0] r_rr_ptr;
    cmd_word_t            r_out_data;
    logic [PORT_BITS-1:0] r_out_tid;

    logic [NUM_PORTS-1:0] w_elig;
    logic                 w_grant_valid;
    logic [PORT_BITS-1:0] w_grant_idx;
    cmd_word_t            w_sel_data;
    logic                 w_accept;

`ifdef LOCK_ARB_UNLOCK_PRIO_EN
    // When any valid port holds an unlock, only those ports compete.
    logic [NUM_PORTS-1:0] w_unlock;
    always_comb begin
        w_unlock = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            w_unlock[i] = inStream_TVALID[i] &&
                (cmd_code_t'(inStream_TDATA[TDATA_W*i + CMD_TYPE_L +: CMD_W]) ==
                 cmd_code_t'(CMD_UNLOCK_CODE));
    end
    assign w_elig = (|w_unlock) ? w_unlock : inStream_TVALID;
`else
    assign w_elig = inStream_TVALID;
`endif

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_BITS (PORT_BITS)
    ) u_rr (
        .i_elig        (w_elig),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    // rstn gates the ready so a grant in a reset cycle consumes nothing.
    assign w_accept = rstn && (r_state == ST_IDLE) && w_grant_valid;

    always_comb begin
        inStream_TREADY = '0;
        w_sel_data      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant_idx == PORT_BITS'(i)) begin
                inStream_TREADY[i] = w_accept;
                w_sel_data         = inStream_TDATA[TDATA_W*i +: TDATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_out_data <= '0;
            r_out_tid  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_out_data <= w_sel_data;
                        r_out_tid  <= w_grant_idx;
                        r_state    <= ST_SEND;
                    end
                end
                default: begin
                    if (outStream_TREADY) begin
                        // Pointer moves past the port just served.
                        r_rr_ptr <= (r_out_tid == PORT_BITS'(NUM_PORTS - 1)) ?
                                    '0 : r_out_tid + 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign outStream_TVALID = (r_state == ST_SEND);
    assign outStream_TDATA  = r_out_data;
    assign outStream_TID    = TID_W'(r_out_tid);

endmodule

// File: tb/tb_lock_cmd_arbiter.sv
module tb_lock_cmd_arbiter;

    logic           clk;
    logic           rstn;
    logic [255:0]   in_data;
    logic [3:0]     in_valid;
    logic [3:0]     in_ready;
    logic [63:0]    out_data;
    logic           out_valid;
    logic           out_ready;
    logic [3:0]     out_tid;

    logic [63:0]    d1;
    logic           v1;
    logic           r1;
    logic [63:0]    o1_data;
    logic           o1_valid;
    logic           o1_ready;
    logic [3:0]     o1_tid;

    int cmp_cnt;
    int err_cnt;

    lock_cmd_arbiter #(.NUM_PORTS(4), .PORT_BITS(4)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .inStream_TDATA   (in_data),
        .inStream_TVALID  (in_valid),
        .inStream_TREADY  (in_ready),
        .outStream_TDATA  (out_data),
        .outStream_TVALID (out_valid),
        .outStream_TREADY (out_ready),
        .outStream_TID    (out_tid)
    );

    lock_cmd_arbiter #(.NUM_PORTS(1), .PORT_BITS(1)) dut1 (
        .clk              (clk),
        .rstn             (rstn),
        .inStream_TDATA   (d1),
        .inStream_TVALID  (v1),
        .inStream_TREADY  (r1),
        .outStream_TDATA  (o1_data),
        .outStream_TVALID (o1_valid),
        .outStream_TREADY (o1_ready),
        .outStream_TID    (o1_tid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [63:0] pdat(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'h0000_0010};
    endfunction

    function automatic logic [63:0] cdat(input int k);
        return {32'h5100_0000 + 32'(k), 32'h0000_0020};
    endfunction

    initial begin
        int first, second;
        cmp_cnt   = 0;
        err_cnt   = 0;
        rstn      = 1'b0;
        in_data   = '0;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        d1        = '0;
        v1        = 1'b0;
        o1_ready  = 1'b0;

        // Reset: ready forced low even with a valid request present.
        tick();
        tick();
        smp();
        chk("rst_tready", 64'(in_ready), 64'h0);
        chk("rst_tvalid", 64'(out_valid), 64'h0);
        chk("rst_tdata", out_data, 64'h0);
        chk("rst_tid", 64'(out_tid), 64'h0);
        chk("rst_rrptr", 64'(dut.r_rr_ptr), 64'h0);
        tick();
        in_valid = 4'b0000;
        rstn     = 1'b1;

        // Single command from port 2.
        in_data[128 +: 64] = 64'h0000_0000_0000_1204;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        smp();
        chk("t1_tready", 64'(in_ready), 64'h4);
        chk("t1_tvalid_idle", 64'(out_valid), 64'h0);
        tick();
        in_valid = 4'b0000;
        smp();
        chk("t1_tvalid", 64'(out_valid), 64'h1);
        chk("t1_tdata", out_data, 64'h0000_0000_0000_1204);
        chk("t1_tid", 64'(out_tid), 64'h2);
        chk("t1_tready_send", 64'(in_ready), 64'h0);
        tick();
        smp();
        chk("t1_rrptr", 64'(dut.r_rr_ptr), 64'h3);
        chk("t1_tvalid_back", 64'(out_valid), 64'h0);

        // Re-reset so the round-robin starts from port 0.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) in_data[64*i +: 64] = pdat(i);
        in_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            smp();
            chk($sformatf("t2_tready_%0d", g), 64'(in_ready), 64'(4'b0001 << (g % 4)));
            chk($sformatf("t2_idle_%0d", g), 64'(out_valid), 64'h0);
            tick();
            smp();
            chk($sformatf("t2_tvalid_%0d", g), 64'(out_valid), 64'h1);
            chk($sformatf("t2_tid_%0d", g), 64'(out_tid), 64'(g % 4));
            chk($sformatf("t2_tdata_%0d", g), out_data, pdat(g % 4));
            tick();
        end

        // Backpressure: port 1 held valid, lock block stalls 5 cycles.
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        smp();
        chk("t3_tready", 64'(in_ready), 64'h2);
        tick();
        for (int c = 0; c < 5; c++) begin
            smp();
            chk($sformatf("t3_tvalid_%0d", c), 64'(out_valid), 64'h1);
            chk($sformatf("t3_tid_%0d", c), 64'(out_tid), 64'h1);
            chk($sformatf("t3_tdata_%0d", c), out_data, pdat(1));
            chk($sformatf("t3_tready_%0d", c), 64'(in_ready), 64'h0);
            tick();
        end
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        tick();
        smp();
        chk("t3_rrptr", 64'(dut.r_rr_ptr), 64'h2);

        // Lock on port 0 vs unlock on port 3, pointer at 0.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        in_data[0   +: 64] = 64'hAAAA_0000_0000_0004;
        in_data[192 +: 64] = 64'hBBBB_0000_0000_0005;
        in_valid = 4'b1001;
`ifdef LOCK_ARB_UNLOCK_PRIO_EN
        first  = 3;
        second = 0;
`else
        first  = 0;
        second = 3;
`endif
        smp();
        chk("t4_first_tready", 64'(in_ready), 64'(4'b0001 << first));
        tick();
        in_valid[first] = 1'b0;
        smp();
        chk("t4_first_tid", 64'(out_tid), 64'(first));
        tick();
        smp();
        chk("t4_second_tready", 64'(in_ready), 64'(4'b0001 << second));
        tick();
        in_valid[second] = 1'b0;
        smp();
        chk("t4_second_tid", 64'(out_tid), 64'(second));
        chk("t4_second_tdata", out_data, (second == 3) ? 64'hBBBB_0000_0000_0005
                                                       : 64'hAAAA_0000_0000_0004);
        tick();

        // Reset while in SEND drops the pending command.
        in_data[64 +: 64] = 64'hDEAD_BEEF_0000_0004;
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        smp();
        chk("t5_tready", 64'(in_ready), 64'h2);
        tick();
        in_valid = 4'b0000;
        smp();
        chk("t5_tvalid_send", 64'(out_valid), 64'h1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        smp();
        chk("t5_tvalid_after", 64'(out_valid), 64'h0);
        chk("t5_rrptr", 64'(dut.r_rr_ptr), 64'h0);
        chk("t5_tdata", out_data, 64'h0);
        out_ready = 1'b1;
        tick();
        smp();
        chk("t5_no_reemit_a", 64'(out_valid), 64'h0);
        tick();
        smp();
        chk("t5_no_reemit_b", 64'(out_valid), 64'h0);
        tick();

        // Single-port instance: back-to-back commands.
        d1       = cdat(0);
        v1       = 1'b1;
        o1_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk($sformatf("t6_tready_%0d", k), 64'(r1), 64'h1);
            chk($sformatf("t6_idle_%0d", k), 64'(o1_valid), 64'h0);
            tick();
            d1 = cdat(k + 1);
            smp();
            chk($sformatf("t6_tvalid_%0d", k), 64'(o1_valid), 64'h1);
            chk($sformatf("t6_tdata_%0d", k), o1_data, cdat(k));
            chk($sformatf("t6_tid_%0d", k), 64'(o1_tid), 64'h0);
            chk($sformatf("t6_tready_send_%0d", k), 64'(r1), 64'h0);
            tick();
        end
        v1 = 1'b0;
        smp();
        chk("t6_rrptr", 64'(dut1.r_rr_ptr), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
